parking_gate_arbiter: RTL and testbench

// - Shares one parking occupancy counter between N_GATES physical gates. Each gate raises an entry or exit request.
// - Per transaction slot: at most one entry and one exit are serialized onto the counter's car_entered / car_exited strobes.
// - Round-robin arbitration, kept separately for entries and for exits.
// - Entries are admitted only when the counter reports vacancy for the car class; otherwise the request is denied.
// - Drives a per-gate barrier-open timer. Sits between the gate sensors and the occupancy counter.

---
 rtl/parking_pkg.sv | 24 ++
 rtl/parking_gate_arbiter_rr_picker.sv | 30 +++
 rtl/parking_gate_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_parking_gate_arbiter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types and width helpers for the parking gate arbiter.
// Widths are derived from the instantiating module's parameters.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2
  } gate_state_t;

  localparam int N_GATES_DEFAULT          = 4;
  localparam int GATE_OPEN_CYCLES_DEFAULT = 8;
  localparam int SETTLE_CYCLES_DEFAULT    = 2;

  // Barrier timer must be able to hold GATE_OPEN_CYCLES itself.
  function automatic int timer_width(input int open_cycles);
    return $clog2(open_cycles + 1);
  endfunction

  function automatic int ptr_width(input int n_gates);
    return (n_gates < 2) ? 1 : $clog2(n_gates);
  endfunction

endpackage

// File: rtl/parking_gate_arbiter_rr_picker.sv
// Round-robin picker: first set request at or above ptr, wrapping upward.
// Combinational; the caller registers the result.
module rr_picker #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    int cand;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        grant[cand] = 1'b1;
        idx         = PTR_W'(cand);
      end
    end
  end

endmodule

// File: rtl/parking_gate_arbiter.sv
// Serialises gate entry/exit requests onto a shared occupancy counter,
// one entry and one exit per slot, with per-gate barrier-open timers.
module parking_gate_arbiter
  import parking_pkg::*;
#(
  parameter int N_GATES          = N_GATES_DEFAULT,
  parameter int GATE_OPEN_CYCLES = GATE_OPEN_CYCLES_DEFAULT,
  parameter int SETTLE_CYCLES    = SETTLE_CYCLES_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_GATES-1:0] gate_req,
  input  logic [N_GATES-1:0] gate_is_exit,
  input  logic [N_GATES-1:0] gate_is_uni,
  input  logic               uni_is_vacated_space,
  input  logic               is_vacated_space,
  output logic               car_entered,
  output logic               is_uni_car_entered,
  output logic               car_exited,
  output logic               is_uni_car_exited,
  output logic [N_GATES-1:0] gate_ack,
  output logic [N_GATES-1:0] gate_deny,
  output logic [N_GATES-1:0] gate_open,
  output logic               busy
);

  localparam int PTR_W    = ptr_width(N_GATES);
  localparam int TIMER_W  = timer_width(GATE_OPEN_CYCLES);
  localparam int SETTLE_W = $clog2(SETTLE_CYCLES);

  gate_state_t state_reg, state_next;

  logic [PTR_W-1:0]    entry_ptr_reg, entry_ptr_next;
  logic [PTR_W-1:0]    exit_ptr_reg, exit_ptr_next;
  logic                entry_win_reg, entry_win_next;
  logic [PTR_W-1:0]    entry_idx_reg, entry_idx_next;
  logic                entry_uni_reg, entry_uni_next;
  logic                exit_win_reg, exit_win_next;
  logic [PTR_W-1:0]    exit_idx_reg, exit_idx_next;
  logic                exit_uni_reg, exit_uni_next;
  logic [SETTLE_W-1:0] settle_cnt_reg, settle_cnt_next;

  logic                car_entered_reg, car_entered_next;
  logic                uni_entered_reg, uni_entered_next;
  logic                car_exited_reg, car_exited_next;
  logic                uni_exited_reg, uni_exited_next;
  logic [N_GATES-1:0]  ack_reg, ack_next;
  logic [N_GATES-1:0]  deny_reg, deny_next;

  logic [TIMER_W-1:0]  timer_reg [N_GATES];

  logic [N_GATES-1:0]  eligible, entry_cand, exit_cand;
  logic [N_GATES-1:0]  entry_grant, exit_grant;
  logic [PTR_W-1:0]    entry_pick, exit_pick;
  logic                entry_found, exit_found;
  logic                entry_vacancy;

  // A gate whose barrier is still open cannot compete again.
  assign eligible   = gate_req & ~gate_open;
  assign entry_cand = eligible & ~gate_is_exit;
  assign exit_cand  = eligible & gate_is_exit;

  rr_picker #(.N(N_GATES), .PTR_W(PTR_W)) u_entry_picker (
    .req   (entry_cand),
    .ptr   (entry_ptr_reg),
    .grant (entry_grant),
    .idx   (entry_pick),
    .valid (entry_found)
  );

  rr_picker #(.N(N_GATES), .PTR_W(PTR_W)) u_exit_picker (
    .req   (exit_cand),
    .ptr   (exit_ptr_reg),
    .grant (exit_grant),
    .idx   (exit_pick),
    .valid (exit_found)
  );

  function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] idx);
    return (idx == PTR_W'(N_GATES - 1)) ? '0 : idx + PTR_W'(1);
  endfunction

  assign entry_vacancy = entry_uni_reg ? uni_is_vacated_space : is_vacated_space;

  always_comb begin
    state_next       = state_reg;
    entry_ptr_next   = entry_ptr_reg;
    exit_ptr_next    = exit_ptr_reg;
    entry_win_next   = entry_win_reg;
    entry_idx_next   = entry_idx_reg;
    entry_uni_next   = entry_uni_reg;
    exit_win_next    = exit_win_reg;
    exit_idx_next    = exit_idx_reg;
    exit_uni_next    = exit_uni_reg;
    settle_cnt_next  = settle_cnt_reg;
    car_entered_next = 1'b0;
    uni_entered_next = 1'b0;
    car_exited_next  = 1'b0;
    uni_exited_next  = 1'b0;
    ack_next         = '0;
    deny_next        = '0;

    case (state_reg)
      IDLE: begin
        // Winner and class are captured here so a request dropped later still completes.
        if (entry_found || exit_found) begin
          state_next     = ISSUE;
          entry_win_next = entry_found;
          entry_idx_next = entry_pick;
          entry_uni_next = |(entry_grant & gate_is_uni);
          exit_win_next  = exit_found;
          exit_idx_next  = exit_pick;
          exit_uni_next  = |(exit_grant & gate_is_uni);
        end
      end

      ISSUE: begin
        state_next      = SETTLE;
        settle_cnt_next = '0;
        if (exit_win_reg) begin
          car_exited_next         = 1'b1;
          uni_exited_next         = exit_uni_reg;
          ack_next[exit_idx_reg]  = 1'b1;
          exit_ptr_next           = ptr_after(exit_idx_reg);
        end
        if (entry_win_reg) begin
          if (entry_vacancy) begin
            car_entered_next        = 1'b1;
            uni_entered_next        = entry_uni_reg;
            ack_next[entry_idx_reg] = 1'b1;
          end else begin
            deny_next[entry_idx_reg] = 1'b1;
          end
          entry_ptr_next = ptr_after(entry_idx_reg);
        end
      end

      SETTLE: begin
        if (settle_cnt_reg == SETTLE_W'(SETTLE_CYCLES - 1)) begin
          state_next = IDLE;
        end else begin
          settle_cnt_next = settle_cnt_reg + SETTLE_W'(1);
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      entry_ptr_reg   <= '0;
      exit_ptr_reg    <= '0;
      entry_win_reg   <= 1'b0;
      entry_idx_reg   <= '0;
      entry_uni_reg   <= 1'b0;
      exit_win_reg    <= 1'b0;
      exit_idx_reg    <= '0;
      exit_uni_reg    <= 1'b0;
      settle_cnt_reg  <= '0;
      car_entered_reg <= 1'b0;
      uni_entered_reg <= 1'b0;
      car_exited_reg  <= 1'b0;
      uni_exited_reg  <= 1'b0;
      ack_reg         <= '0;
      deny_reg        <= '0;
    end else begin
      state_reg       <= state_next;
      entry_ptr_reg   <= entry_ptr_next;
      exit_ptr_reg    <= exit_ptr_next;
      entry_win_reg   <= entry_win_next;
      entry_idx_reg   <= entry_idx_next;
      entry_uni_reg   <= entry_uni_next;
      exit_win_reg    <= exit_win_next;
      exit_idx_reg    <= exit_idx_next;
      exit_uni_reg    <= exit_uni_next;
      settle_cnt_reg  <= settle_cnt_next;
      car_entered_reg <= car_entered_next;
      uni_entered_reg <= uni_entered_next;
      car_exited_reg  <= car_exited_next;
      uni_exited_reg  <= uni_exited_next;
      ack_reg         <= ack_next;
      deny_reg        <= deny_next;
    end
  end

  // Timer loads on the same edge that registers the ack, so the barrier rises with it.
  for (genvar gi = 0; gi < N_GATES; gi++) begin : g_open
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        timer_reg[gi] <= '0;
      end else if (ack_next[gi]) begin
        timer_reg[gi] <= TIMER_W'(GATE_OPEN_CYCLES);
      end else if (timer_reg[gi] != '0) begin
        timer_reg[gi] <= timer_reg[gi] - TIMER_W'(1);
      end
    end
    assign gate_open[gi] = (timer_reg[gi] != '0);
  end

  assign car_entered        = car_entered_reg;
  assign is_uni_car_entered = uni_entered_reg;
  assign car_exited         = car_exited_reg;
  assign is_uni_car_exited  = uni_exited_reg;
  assign gate_ack           = ack_reg;
  assign gate_deny          = deny_reg;
  assign busy               = (state_reg != IDLE);

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed bench for parking_gate_arbiter (4 gates, 8-cycle barrier, 2-cycle settle).
module tb_parking_gate_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] gate_req = '0;
  logic [3:0] gate_is_exit = '0;
  logic [3:0] gate_is_uni = '0;
  logic       uni_is_vacated_space = 1'b0;
  logic       is_vacated_space = 1'b0;
  logic       car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
  logic [3:0] gate_ack, gate_deny, gate_open;
  logic       busy;

  int checks = 0;
  int errors = 0;

  parking_gate_arbiter #(
    .N_GATES(4), .GATE_OPEN_CYCLES(8), .SETTLE_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst),
    .gate_req(gate_req), .gate_is_exit(gate_is_exit), .gate_is_uni(gate_is_uni),
    .uni_is_vacated_space(uni_is_vacated_space), .is_vacated_space(is_vacated_space),
    .car_entered(car_entered), .is_uni_car_entered(is_uni_car_entered),
    .car_exited(car_exited), .is_uni_car_exited(is_uni_car_exited),
    .gate_ack(gate_ack), .gate_deny(gate_deny), .gate_open(gate_open), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_wait(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int open_cnt;
    int ack_idx[$];
    int ack_cyc[$];
    int exp_order[3];
    logic saw_strobe;

    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 3;

    // Reset state
    idle_wait(2);
    check("rst_outputs", 32'({car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
                              gate_ack, gate_deny, gate_open, busy}), 32'd0);
    rst = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // Single uni entry on gate 0
    uni_is_vacated_space = 1'b1;
    is_vacated_space     = 1'b1;
    gate_is_uni          = 4'b0001;
    gate_req             = 4'b0001;
    tick();
    check("single_busy_t1", 32'(busy), 32'd1);
    check("single_no_strobe_t1", 32'(car_entered), 32'd0);
    tick();
    check("single_entered", 32'(car_entered), 32'd1);
    check("single_uni", 32'(is_uni_car_entered), 32'd1);
    check("single_ack", 32'(gate_ack), 32'h1);
    check("single_deny", 32'(gate_deny), 32'h0);
    gate_req = '0;
    open_cnt = gate_open[0] ? 1 : 0;
    tick();
    check("single_strobe_1cyc", 32'({car_entered, gate_ack}), 32'd0);
    if (gate_open[0]) open_cnt++;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (gate_open[0]) open_cnt++;
    end
    check("single_open_cycles", 32'(open_cnt), 32'd8);

    // Full lot: misc entry on gate 2 denied, then admitted once vacancy returns
    is_vacated_space = 1'b0;
    gate_is_uni      = 4'b0000;
    gate_req         = 4'b0100;
    tick();
    tick();
    check("full_deny", 32'(gate_deny), 32'h4);
    check("full_no_ack", 32'(gate_ack), 32'h0);
    check("full_no_entered", 32'(car_entered), 32'd0);
    check("full_gate_closed", 32'(gate_open), 32'h0);
    is_vacated_space = 1'b1;
    idle_wait(4);
    check("full_retry_ack", 32'(gate_ack), 32'h4);
    check("full_retry_entered", 32'({car_entered, is_uni_car_entered}), 32'b10);
    check("full_retry_open", 32'(gate_open), 32'h4);
    gate_req = '0;
    idle_wait(12);

    // Reset while the entry strobe is high
    gate_req = 4'b0010;
    tick();
    tick();
    check("mid_entered_before_rst", 32'(car_entered), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_outputs", 32'({car_entered, car_exited, gate_ack, gate_deny, gate_open, busy}), 32'd0);
    gate_req = '0;
    tick();
    rst = 1'b0;
    saw_strobe = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (car_entered || car_exited || gate_ack != 0) saw_strobe = 1'b1;
    end
    check("mid_no_replay", 32'(saw_strobe), 32'd0);

    // Round robin: gates 0,1,3 entering continuously
    gate_req = 4'b1011;
    for (int c = 1; c <= 24; c++) begin
      tick();
      if (gate_ack != 0) begin
        for (int g = 0; g < 4; g++) if (gate_ack[g]) ack_idx.push_back(g);
        ack_cyc.push_back(c);
      end
    end
    gate_req = '0;
    check("rr_ack_count", 32'(ack_idx.size()), 32'd6);
    check("rr_first_latency", 32'((ack_cyc.size() > 0) ? ack_cyc[0] : -1), 32'd2);
    for (int i = 0; i < 6; i++) begin
      if (i < ack_idx.size()) begin
        check($sformatf("rr_order_%0d", i), 32'(ack_idx[i]), 32'(exp_order[i % 3]));
        if (i > 0) check($sformatf("rr_spacing_%0d", i), 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd4);
      end
    end
    idle_wait(12);

    // Simultaneous exit (gate 1, uni) and entry (gate 2, misc)
    gate_is_exit = 4'b0010;
    gate_is_uni  = 4'b0010;
    gate_req     = 4'b0110;
    tick();
    tick();
    check("sim_strobes", 32'({car_exited, is_uni_car_exited, car_entered, is_uni_car_entered}), 32'b1110);
    check("sim_ack", 32'(gate_ack), 32'h6);
    check("sim_deny", 32'(gate_deny), 32'h0);
    gate_req     = '0;
    gate_is_exit = '0;
    gate_is_uni  = '0;
    idle_wait(12);

    // Settle: counter reports full after the first admission; second entry must be denied
    gate_req = 4'b1001;
    tick();
    tick();
    check("settle_first_ack", 32'(gate_ack), 32'h8);
    check("settle_first_entered", 32'(car_entered), 32'd1);
    tick();
    tick();
    is_vacated_space = 1'b0;
    tick();
    tick();
    check("settle_second_deny", 32'(gate_deny), 32'h1);
    check("settle_no_overadmit", 32'({car_entered, is_uni_car_entered, gate_ack}), 32'd0);
    gate_req = '0;
    idle_wait(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
